// File: rtl/mem_stage.sv
// mem_stage -- memory-access pipeline stage (EX/MEM -> MEM/WB).
//
// Runs a single-outstanding-access FSM (IDLE -> BUSY -> DONE) on a
// req/ack data-memory port. The pipeline is stalled from the cycle a memory
// op is seen in IDLE until the DONE cycle, when the loaded data is presented
// to writeback. Non-memory ops and bubbles pass through combinationally.
//
// Optional build macro: MEM_TIMEOUT_EN -- adds a BUSY watchdog that aborts
// an access after TIMEOUT_CYCLES BUSY cycles without ack and sets a sticky
// mem_err. Without it, BUSY waits for ack indefinitely and mem_err is 0.
//
// Parameters:
//   TIMEOUT_CYCLES  BUSY-cycle limit before abort (1..255), timeout build only
//
// Ports:
//   clk         in   stage clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   M_in        in   41-bit EX/MEM bundle
//                    [40:25] alu_result [24:9] store_data [8:5] wr_reg
//                    [4] MemWrite [3] MemtoReg [2] RegWrite [1] Halt [0] MemRead
//   M_valid     in   M_in holds a real instruction (0 = bubble)
//   W_out       out  39-bit MEM/WB bundle
//                    [38:23] mem_data [22:7] alu_result [6:3] wr_reg
//                    [2] MemtoReg [1] RegWrite [0] Halt
//   stall_M     out  freezes PC, IF/ID, ID/EX and EX/MEM
//   dmem_req    out  memory request, high exactly in BUSY
//   dmem_we     out  write strobe (qualified by dmem_req)
//   dmem_addr   out  word address (alu_result)
//   dmem_wdata  out  store data
//   dmem_rdata  in   read data, valid with dmem_ack
//   dmem_ack    in   one-cycle access-complete pulse
//   mem_err     out  sticky timeout flag

module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [40:0] M_in,
  input  logic        M_valid,
  output logic [38:0] W_out,
  output logic        stall_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value on the last permitted BUSY cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [15:0] alu_result;
  logic [15:0] store_data;
  logic [3:0]  wr_reg;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic        halt;
  logic        mem_read;

  assign alu_result = M_in[40:25];
  assign store_data = M_in[24:9];
  assign wr_reg     = M_in[8:5];
  assign mem_write  = M_in[4];
  assign mem_to_reg = M_in[3];
  assign reg_write  = M_in[2];
  assign halt       = M_in[1];
  assign mem_read   = M_in[0];

  logic mem_op;
  logic is_read;

  // Write takes priority when both MemRead and MemWrite are set.
  assign mem_op  = M_valid & (mem_read | mem_write);
  assign is_read = M_valid & mem_read & ~mem_write;

  state_t      state;
  logic [15:0] rdata_q;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] busy_cnt;
  logic       err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rdata_q  <= '0;
      busy_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state    <= BUSY;
            busy_cnt <= '0;
          end
        end
        BUSY: begin
          // Ack is checked first so a coincident timeout loses.
          if (dmem_ack) begin
            state <= DONE;
            if (is_read) rdata_q <= dmem_rdata;
          end else if (busy_cnt == TO_LAST) begin
            state   <= DONE;
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            busy_cnt <= busy_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_err = err_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (mem_op) state <= BUSY;
        BUSY: begin
          if (dmem_ack) begin
            state <= DONE;
            if (is_read) rdata_q <= dmem_rdata;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TO_LAST;
  assign mem_err = 1'b0;
`endif

  // Request decodes straight from the registered state; address, data and
  // strobe come from M_in, which is frozen by stall_M during the access.
  assign dmem_req   = (state == BUSY);
  assign dmem_we    = mem_write;
  assign dmem_addr  = alu_result;
  assign dmem_wdata = store_data;

  assign stall_M = (state == BUSY) | ((state == IDLE) & mem_op);

  assign W_out = {(is_read ? rdata_q : 16'h0000),
                  alu_result,
                  wr_reg,
                  mem_to_reg,
                  reg_write & M_valid,
                  halt & M_valid};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed bench for mem_stage: a table of combinational
// pass-through vectors taken in IDLE, then hand-written multi-cycle sequences
// for load, store, read+write priority, asynchronous reset mid-access and
// the BUSY wait / timeout behaviour.

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [40:0] M_in = '0;
  logic        M_valid = 1'b0;
  logic [38:0] W_out;
  logic        stall_M;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .M_in       (M_in),
    .M_valid    (M_valid),
    .W_out      (W_out),
    .stall_M    (stall_M),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .mem_err    (mem_err)
  );

  function automatic logic [40:0] pack(input logic [15:0] alu, input logic [15:0] sd,
                                       input logic [3:0] wr, input logic mw, input logic m2r,
                                       input logic rw, input logic hlt, input logic mr);
    return {alu, sd, wr, mw, m2r, rw, hlt, mr};
  endfunction

  function automatic logic [38:0] wb(input logic [15:0] md, input logic [15:0] alu,
                                     input logic [3:0] wr, input logic m2r,
                                     input logic rw, input logic hlt);
    return {md, alu, wr, m2r, rw, hlt};
  endfunction

  task automatic chk(input string name, input logic [38:0] act, input logic [38:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, like a pipeline register.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic        valid;
    logic [15:0] alu;
    logic [15:0] sd;
    logic [3:0]  wr;
    logic        mw, m2r, rw, hlt, mr, ack;
    logic        exp_stall;
    logic [38:0] exp_w;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // name, valid, alu, sd, wr, mw, m2r, rw, hlt, mr, ack, stall, W_out
    vecs[0] = '{"alu_op",       1'b1, 16'h1234, 16'h0000, 4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                wb(16'h0000, 16'h1234, 4'd3, 1'b0, 1'b1, 1'b0)};
    vecs[1] = '{"bubble_load",  1'b0, 16'h0040, 16'h0000, 4'd5,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                wb(16'h0000, 16'h0040, 4'd5, 1'b1, 1'b0, 1'b0)};
    vecs[2] = '{"halt",         1'b1, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                wb(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1)};
    vecs[3] = '{"bubble_store", 1'b0, 16'h0010, 16'hABCD, 4'd7,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                wb(16'h0000, 16'h0010, 4'd7, 1'b0, 1'b0, 1'b0)};
    vecs[4] = '{"load_idle",    1'b1, 16'h00AA, 16'h0000, 4'd2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                wb(16'h0000, 16'h00AA, 4'd2, 1'b1, 1'b1, 1'b0)};
    vecs[5] = '{"store_idle",   1'b1, 16'h0022, 16'h7777, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                wb(16'h0000, 16'h0022, 4'd0, 1'b0, 1'b0, 1'b0)};
    vecs[6] = '{"alu_halt",     1'b1, 16'hFFFF, 16'h0000, 4'd15, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                wb(16'h0000, 16'hFFFF, 4'd15, 1'b0, 1'b1, 1'b1)};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req",   39'(dmem_req), 39'(1'b0));
    chk("reset_stall", 39'(stall_M),  39'(1'b0));
    chk("reset_err",   39'(mem_err),  39'(1'b0));

    // Pass-through table. Mem ops are withdrawn before the next edge so the
    // FSM stays in IDLE; a set ack is held across that edge (spurious ack).
    foreach (vecs[i]) begin
      adv();
      M_in     = pack(vecs[i].alu, vecs[i].sd, vecs[i].wr, vecs[i].mw, vecs[i].m2r,
                      vecs[i].rw, vecs[i].hlt, vecs[i].mr);
      M_valid  = vecs[i].valid;
      dmem_ack = vecs[i].ack;
      @(negedge clk);
      chk({vecs[i].name, "_stall"}, 39'(stall_M),   39'(vecs[i].exp_stall));
      chk({vecs[i].name, "_req"},   39'(dmem_req),  39'(1'b0));
      chk({vecs[i].name, "_addr"},  39'(dmem_addr), 39'(vecs[i].alu));
      chk({vecs[i].name, "_wdata"}, 39'(dmem_wdata),39'(vecs[i].sd));
      chk({vecs[i].name, "_we"},    39'(dmem_we),   39'(vecs[i].mw));
      chk({vecs[i].name, "_wout"},  W_out,          vecs[i].exp_w);
      #1 M_valid = 1'b0;
    end
    adv();
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("after_spurious_req", 39'(dmem_req), 39'(1'b0));

    // Load 0x0040, ack on second BUSY cycle with 0xBEEF.
    adv();
    M_in = pack(16'h0040, 16'h0000, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    M_valid = 1'b1;
    @(negedge clk);
    chk("ld_idle_stall", 39'(stall_M),  39'(1'b1));
    chk("ld_idle_req",   39'(dmem_req), 39'(1'b0));
    adv();
    @(negedge clk);
    chk("ld_busy1_req",   39'(dmem_req), 39'(1'b1));
    chk("ld_busy1_stall", 39'(stall_M),  39'(1'b1));
    chk("ld_busy1_we",    39'(dmem_we),  39'(1'b0));
    chk("ld_busy1_addr",  39'(dmem_addr),39'(16'h0040));
    adv();
    dmem_ack = 1'b1;
    dmem_rdata = 16'hBEEF;
    @(negedge clk);
    chk("ld_busy2_req",   39'(dmem_req), 39'(1'b1));
    chk("ld_busy2_stall", 39'(stall_M),  39'(1'b1));
    adv();
    dmem_ack = 1'b0;
    dmem_rdata = 16'h0000;
    @(negedge clk);
    chk("ld_done_stall", 39'(stall_M),  39'(1'b0));
    chk("ld_done_req",   39'(dmem_req), 39'(1'b0));
    chk("ld_done_wout",  W_out, wb(16'hBEEF, 16'h0040, 4'd6, 1'b1, 1'b1, 1'b0));
    adv();
    M_valid = 1'b0;
    @(negedge clk);
    chk("ld_after_stall", 39'(stall_M), 39'(1'b0));

    // Store 0x5A5A to 0x0010, ack on first BUSY cycle.
    adv();
    M_in = pack(16'h0010, 16'h5A5A, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    M_valid = 1'b1;
    @(negedge clk);
    chk("st_idle_stall", 39'(stall_M),  39'(1'b1));
    chk("st_idle_req",   39'(dmem_req), 39'(1'b0));
    adv();
    dmem_ack = 1'b1;
    dmem_rdata = 16'h1111;
    @(negedge clk);
    chk("st_busy_req",   39'(dmem_req),   39'(1'b1));
    chk("st_busy_we",    39'(dmem_we),    39'(1'b1));
    chk("st_busy_addr",  39'(dmem_addr),  39'(16'h0010));
    chk("st_busy_wdata", 39'(dmem_wdata), 39'(16'h5A5A));
    chk("st_busy_stall", 39'(stall_M),    39'(1'b1));
    adv();
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("st_done_stall", 39'(stall_M), 39'(1'b0));
    chk("st_done_req",   39'(dmem_req),39'(1'b0));
    chk("st_done_wout",  W_out, wb(16'h0000, 16'h0010, 4'd0, 1'b0, 1'b0, 1'b0));

    // MemRead and MemWrite together: treated as a write, rdata not captured.
    adv();
    M_in = pack(16'h0020, 16'h3333, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    adv();
    dmem_ack = 1'b1;
    dmem_rdata = 16'h2222;
    @(negedge clk);
    chk("rw_busy_we", 39'(dmem_we), 39'(1'b1));
    adv();
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("rw_done_wout", W_out, wb(16'h0000, 16'h0020, 4'd1, 1'b1, 1'b1, 1'b0));
    // A load in IDLE exposes rdata_q: must still hold the earlier 0xBEEF.
    adv();
    M_in = pack(16'h0060, 16'h0000, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("rw_rdata_kept", W_out, wb(16'hBEEF, 16'h0060, 4'd4, 1'b1, 1'b1, 1'b0));
    #1 M_valid = 1'b0;

    // Asynchronous reset in BUSY, then a late ack for the abandoned access.
    adv();
    M_in = pack(16'h0080, 16'h0000, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    M_valid = 1'b1;
    adv();
    @(negedge clk);
    chk("rst_busy_req", 39'(dmem_req), 39'(1'b1));
    #1 rst_n = 1'b0;
    M_valid = 1'b0;
    #1;
    chk("rst_async_req",   39'(dmem_req), 39'(1'b0));
    chk("rst_async_stall", 39'(stall_M),  39'(1'b0));
    chk("rst_async_err",   39'(mem_err),  39'(1'b0));
    dmem_ack = 1'b1;
    dmem_rdata = 16'hDEAD;
    adv();
    rst_n = 1'b1;
    adv();
    dmem_ack = 1'b0;
    M_valid = 1'b1;
    @(negedge clk);
    chk("rst_late_ack_req", 39'(dmem_req), 39'(1'b0));
    chk("rst_rdata_clear",  W_out, wb(16'h0000, 16'h0080, 4'd9, 1'b1, 1'b1, 1'b0));
    adv();
    adv();
    dmem_ack = 1'b1;
    dmem_rdata = 16'h0BAD;
    adv();
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("rst_reload_wout", W_out, wb(16'h0BAD, 16'h0080, 4'd9, 1'b1, 1'b1, 1'b0));
    adv();
    M_valid = 1'b0;

`ifdef MEM_TIMEOUT_EN
    // Load with no ack: four BUSY cycles, then DONE with zero data and error.
    adv();
    M_in = pack(16'h0400, 16'h0000, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    M_valid = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      adv();
      @(negedge clk);
      chk($sformatf("to_busy%0d_req", k), 39'(dmem_req), 39'(1'b1));
    end
    adv();
    @(negedge clk);
    chk("to_done_req",  39'(dmem_req), 39'(1'b0));
    chk("to_done_wout", W_out, wb(16'h0000, 16'h0400, 4'd8, 1'b1, 1'b1, 1'b0));
    chk("to_done_err",  39'(mem_err), 39'(1'b1));
    adv();
    M_in = pack(16'h0500, 16'h0000, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    adv();
    dmem_ack = 1'b1;
    dmem_rdata = 16'h4242;
    adv();
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("to_next_wout", W_out, wb(16'h4242, 16'h0500, 4'd8, 1'b1, 1'b1, 1'b0));
    chk("to_err_sticky", 39'(mem_err), 39'(1'b1));
`else
    // Without the watchdog, BUSY waits well past TIMEOUT_CYCLES for ack.
    adv();
    M_in = pack(16'h0300, 16'h0000, 4'd12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    M_valid = 1'b1;
    for (int unsigned k = 0; k < 10; k++) begin
      adv();
      @(negedge clk);
      chk($sformatf("wait%0d_req", k), 39'(dmem_req), 39'(1'b1));
    end
    adv();
    dmem_ack = 1'b1;
    dmem_rdata = 16'h1357;
    adv();
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("wait_done_wout", W_out, wb(16'h1357, 16'h0300, 4'd12, 1'b1, 1'b1, 1'b0));
    chk("wait_done_err",  39'(mem_err), 39'(1'b0));
`endif
    adv();
    M_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
